sr_bank_arbiter: RTL and testbench

//  Shares one WIDTH-bit bank of gated SR latches between NREQ requesters.

---
 rtl/sr_bank_arbiter.sv | 155 +++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin arbiter that lends one gated SR latch bank to
// NREQ requesters and sequences the bank enable as setup -> strobe -> hold.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   req[NREQ]          per-client request, held until that client's done
//   set_mask/rst_mask  client k uses bits [k*WIDTH +: WIDTH]
//   gnt[NREQ]          one-hot grant, SETUP through HOLD
//   done[NREQ]         one-cycle pulse to the served client during HOLD
//   lat_s/lat_r/lat_c  drive the latch bank s/r/c inputs
//   busy               high whenever the FSM is not IDLE
module sr_bank_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] set_mask,
  input  logic [NREQ*WIDTH-1:0] rst_mask,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      lat_s,
  output logic [WIDTH-1:0]      lat_r,
  output logic                  lat_c,
  output logic                  busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(PULSE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  lat_s_q, lat_s_d;
  logic [WIDTH-1:0]  lat_r_q, lat_r_d;
  logic              lat_c_q, lat_c_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [WIDTH-1:0]  win_set, win_rst;
  int unsigned       idx;

  // Round-robin search starting at the pointer; first asserted req wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Pick the winner's mask slices with constant part-selects.
  always_comb begin
    win_set = '0;
    win_rst = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == win) begin
        win_set = set_mask[k*WIDTH +: WIDTH];
        win_rst = rst_mask[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    lat_s_d = lat_s_q;
    lat_r_d = lat_r_q;
    lat_c_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SETUP;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          // Set wins on conflict so s and r never overlap on a bit.
          lat_s_d      = win_set;
          lat_r_d      = win_rst & ~win_set;
          busy_d       = 1'b1;
          ptr_d        = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
      end
      SETUP: begin
        state_d = STROBE;
        lat_c_d = 1'b1;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = HOLD;
          done_d  = gnt_q;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          lat_c_d = 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        gnt_d   = '0;
        lat_s_d = '0;
        lat_r_d = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      lat_s_q <= '0;
      lat_r_q <= '0;
      lat_c_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      lat_s_q <= lat_s_d;
      lat_r_q <= lat_r_d;
      lat_c_q <= lat_c_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign lat_s = lat_s_q;
  assign lat_r = lat_r_q;
  assign lat_c = lat_c_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: directed scenarios for sr_bank_arbiter (NREQ=4,
// WIDTH=4, PULSE_CYC=2) with a behavioural gated SR latch bank on the outputs.
module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] set_mask = '0;
  logic [15:0] rst_mask = '0;
  logic [3:0]  gnt, done, lat_s, lat_r;
  logic        lat_c, busy;
  logic [3:0]  bank_q = '0;

  int vecs = 0;
  int errs = 0;

  sr_bank_arbiter #(.NREQ(4), .WIDTH(4), .PULSE_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .set_mask(set_mask), .rst_mask(rst_mask),
    .gnt(gnt), .done(done), .lat_s(lat_s), .lat_r(lat_r), .lat_c(lat_c),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Gated SR latch bank, set has priority; sampled while the enable is high.
  always @(posedge clk) if (lat_c) bank_q <= (bank_q & ~lat_r) | lat_s;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    vecs++; if ({gnt, done, lat_s, lat_r, lat_c, busy} !== 18'b0) begin errs++;
      $display("FAIL reset_outputs got %b exp 0", {gnt, done, lat_s, lat_r, lat_c, busy}); end
    rst = 1'b0;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    set_mask = 16'h8421;
    rst_mask = 16'h0000;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick(); // SETUP
      vecs++; if (gnt !== exp_g) begin errs++; $display("FAIL rr_gnt op%0d got %b exp %b", k, gnt, exp_g); end
      vecs++; if (lat_s !== exp_g) begin errs++; $display("FAIL rr_lat_s op%0d got %h exp %h", k, lat_s, exp_g); end
      tick(); tick(); tick(); // STROBE, STROBE, HOLD
      vecs++; if (done !== exp_g) begin errs++; $display("FAIL rr_done op%0d got %b exp %b", k, done, exp_g); end
      if (k == 4) req = 4'b0000;
      tick(); // IDLE gap
      vecs++; if (busy !== 1'b0 || gnt !== 4'b0) begin errs++;
        $display("FAIL rr_gap op%0d busy %b gnt %b exp 0 0", k, busy, gnt); end
    end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_stop busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    set_mask = 16'h000A;
    rst_mask = 16'h0005;
    req = 4'b0001;
    tick(); // N+1
    vecs++; if (gnt !== 4'b0001 || lat_c !== 1'b0 || busy !== 1'b1) begin errs++;
      $display("FAIL basic_setup gnt %b lat_c %b busy %b exp 0001 0 1", gnt, lat_c, busy); end
    vecs++; if (lat_s !== 4'hA || lat_r !== 4'h5) begin errs++;
      $display("FAIL basic_masks s %h r %h exp A 5", lat_s, lat_r); end
    tick(); // N+2
    vecs++; if (lat_c !== 1'b1) begin errs++; $display("FAIL basic_strobe1 lat_c got %b exp 1", lat_c); end
    tick(); // N+3
    vecs++; if (lat_c !== 1'b1 || done !== 4'b0) begin errs++;
      $display("FAIL basic_strobe2 lat_c %b done %b exp 1 0000", lat_c, done); end
    tick(); // N+4
    vecs++; if (lat_c !== 1'b0 || done !== 4'b0001 || lat_s !== 4'hA) begin errs++;
      $display("FAIL basic_hold lat_c %b done %b s %h exp 0 0001 A", lat_c, done, lat_s); end
    req = 4'b0000;
    tick();
    vecs++; if (gnt !== 4'b0 || lat_s !== 4'h0 || lat_r !== 4'h0 || done !== 4'b0) begin errs++;
      $display("FAIL basic_idle gnt %b s %h r %h done %b exp all 0", gnt, lat_s, lat_r, done); end
    vecs++; if (bank_q !== 4'hA) begin errs++; $display("FAIL basic_bank got %h exp A", bank_q); end
  endtask

  task automatic test_set_wins();
    set_mask = 16'h0F00;
    rst_mask = 16'h5A55;
    req = 4'b0100;
    tick();
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL setwin_gnt got %b exp 0100", gnt); end
    vecs++; if (lat_s !== 4'hF || lat_r !== 4'h0) begin errs++;
      $display("FAIL setwin_masks s %h r %h exp F 0", lat_s, lat_r); end
    tick(); tick(); tick();
    req = 4'b0000;
    tick();
    vecs++; if (bank_q !== 4'hF) begin errs++; $display("FAIL setwin_bank got %h exp F", bank_q); end
  endtask

  task automatic test_mask_change();
    set_mask = 16'h3000;
    rst_mask = 16'hC000;
    req = 4'b1000;
    tick(); // SETUP
    vecs++; if (gnt !== 4'b1000 || lat_s !== 4'h3 || lat_r !== 4'hC) begin errs++;
      $display("FAIL mchg_setup gnt %b s %h r %h exp 1000 3 C", gnt, lat_s, lat_r); end
    tick(); // STROBE1
    set_mask = 16'hC000;
    rst_mask = 16'h3000;
    tick(); // STROBE2
    vecs++; if (lat_s !== 4'h3 || lat_r !== 4'hC || lat_c !== 1'b1) begin errs++;
      $display("FAIL mchg_strobe s %h r %h c %b exp 3 C 1", lat_s, lat_r, lat_c); end
    tick(); // HOLD
    vecs++; if (lat_s !== 4'h3 || lat_r !== 4'hC || done !== 4'b1000) begin errs++;
      $display("FAIL mchg_hold s %h r %h done %b exp 3 C 1000", lat_s, lat_r, done); end
    req = 4'b0000;
    tick();
    vecs++; if (bank_q !== 4'h3) begin errs++; $display("FAIL mchg_bank got %h exp 3", bank_q); end
  endtask

  task automatic test_req_drop();
    set_mask = 16'h0000;
    rst_mask = 16'h0000;
    req = 4'b0010;
    tick(); // SETUP
    vecs++; if (gnt !== 4'b0010) begin errs++; $display("FAIL drop_gnt got %b exp 0010", gnt); end
    req = 4'b0000;
    tick(); tick(); tick(); // STROBE, STROBE, HOLD
    vecs++; if (done !== 4'b0010 || gnt !== 4'b0010) begin errs++;
      $display("FAIL drop_done done %b gnt %b exp 0010 0010", done, gnt); end
    tick(); tick(); tick();
    vecs++; if (gnt !== 4'b0 || busy !== 1'b0) begin errs++;
      $display("FAIL drop_noregrant gnt %b busy %b exp 0000 0", gnt, busy); end
    vecs++; if (bank_q !== 4'h3) begin errs++; $display("FAIL drop_bank got %h exp 3", bank_q); end
  endtask

  task automatic test_reset_mid();
    set_mask = 16'h00F0;
    rst_mask = 16'h0000;
    req = 4'b0010;
    tick(); // SETUP, pointer moves to 2
    tick(); // STROBE
    #2 rst = 1'b1; req = 4'b0000;
    #1;
    vecs++; if (lat_c !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin errs++;
      $display("FAIL rstmid_outputs c %b gnt %b busy %b exp 0 0000 0", lat_c, gnt, busy); end
    tick();
    vecs++; if (bank_q !== 4'h3) begin errs++; $display("FAIL rstmid_bank got %h exp 3", bank_q); end
    rst = 1'b0;
    req = 4'b1111;
    tick(); // pointer back at 0 so client 0 wins
    vecs++; if (gnt !== 4'b0001 || busy !== 1'b1) begin errs++;
      $display("FAIL rstmid_regrant gnt %b busy %b exp 0001 1", gnt, busy); end
    tick(); tick(); tick();
    vecs++; if (done !== 4'b0001) begin errs++; $display("FAIL rstmid_done got %b exp 0001", done); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_set_wins();
    test_mask_change();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
